// File: rtl/mmio_ctrl_gen.sv
// MMIO bridge that fans one word-addressed bus out to 2**SLOT_BITS register slots.
// Define MMIO_TIMEOUT_EN to add the wait-cycle limit and the err_timeout flag.
module mmio_ctrl_gen #(
   parameter int SLOT_BITS = 6,
   parameter int REG_AW = 5,
   parameter logic [(1 << SLOT_BITS)-1:0] SLOT_MASK = '1,
   parameter int TIMEOUT = 255
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              mmio_cs,
   input  logic                              mmio_wr,
   input  logic                              mmio_rd,
   input  logic [20:0]                       mmio_addr,
   input  logic [31:0]                       mmio_wr_data,
   output logic [31:0]                       mmio_rd_data,
   output logic                              mmio_ready,
   output logic [(1 << SLOT_BITS)-1:0]       slot_cs,
   output logic                              slot_rd,
   output logic                              slot_wr,
   output logic [REG_AW-1:0]                 slot_reg_addr,
   output logic [31:0]                       slot_wr_data,
   input  logic [(1 << SLOT_BITS)*32-1:0]    slot_rd_data,
   input  logic [(1 << SLOT_BITS)-1:0]       slot_ready,
   output logic                              err_unmapped,
   output logic                              err_timeout,
   input  logic                              err_clr
);

   localparam int N_SLOT = 1 << SLOT_BITS;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      DONE
   } state_t;

   state_t                 state;
   logic [SLOT_BITS-1:0]   lat_slot;
   logic                   lat_write;
   logic [SLOT_BITS-1:0]   req_slot;
   logic [REG_AW-1:0]      req_reg;
   logic                   req_valid;
   logic                   sel_ready;
   logic [31:0]            sel_data;
   logic                   timeout_hit;
   logic                   unused_addr_bits;

   assign req_slot  = mmio_addr[SLOT_BITS+REG_AW-1:REG_AW];
   assign req_reg   = mmio_addr[REG_AW-1:0];
   assign req_valid = mmio_cs & (mmio_rd | mmio_wr);
   assign sel_ready = slot_ready[lat_slot];
   assign sel_data  = slot_rd_data[{lat_slot, 5'b00000} +: 32];
   assign unused_addr_bits = ^mmio_addr[20:SLOT_BITS+REG_AW];

`ifdef MMIO_TIMEOUT_EN
   logic [15:0] wait_cnt;

   // Counts cycles spent in ACCESS/WAIT; sitting at zero in IDLE clears it for the next ACCESS.
   always_ff @(posedge clk) begin
      if (reset || state == IDLE) begin
         wait_cnt <= '0;
      end else if (state == ACCESS || state == WAIT) begin
         wait_cnt <= wait_cnt + 16'd1;
      end
   end

   assign timeout_hit = ({1'b0, wait_cnt} + 17'd1) >= 17'(TIMEOUT);
`else
   logic unused_timeout_cfg;

   assign timeout_hit        = 1'b0;
   assign err_timeout        = 1'b0;
   assign unused_timeout_cfg = (TIMEOUT == 0);
`endif

   // All outputs are registered; results and flags appear together with the mmio_ready pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         lat_slot      <= '0;
         lat_write     <= 1'b0;
         slot_cs       <= '0;
         slot_rd       <= 1'b0;
         slot_wr       <= 1'b0;
         slot_reg_addr <= '0;
         slot_wr_data  <= '0;
         mmio_rd_data  <= '0;
         mmio_ready    <= 1'b0;
         err_unmapped  <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
         err_timeout   <= 1'b0;
`endif
      end else begin
         slot_cs    <= '0;
         slot_rd    <= 1'b0;
         slot_wr    <= 1'b0;
         mmio_ready <= 1'b0;
         if (err_clr) begin
            err_unmapped <= 1'b0;
`ifdef MMIO_TIMEOUT_EN
            err_timeout  <= 1'b0;
`endif
         end
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_slot      <= req_slot;
                  lat_write     <= mmio_wr;
                  slot_reg_addr <= req_reg;
                  slot_wr_data  <= mmio_wr_data;
                  if (SLOT_MASK[req_slot]) begin
                     state   <= ACCESS;
                     slot_cs <= {{(N_SLOT-1){1'b0}}, 1'b1} << req_slot;
                     slot_rd <= ~mmio_wr;
                     slot_wr <= mmio_wr;
                  end else begin
                     state        <= DONE;
                     mmio_ready   <= 1'b1;
                     err_unmapped <= 1'b1;
                     if (!mmio_wr) begin
                        mmio_rd_data <= '1;
                     end
                  end
               end
            end
            ACCESS, WAIT: begin
               if (sel_ready) begin
                  state      <= DONE;
                  mmio_ready <= 1'b1;
                  if (!lat_write) begin
                     mmio_rd_data <= sel_data;
                  end
               end else if (timeout_hit) begin
                  state      <= DONE;
                  mmio_ready <= 1'b1;
`ifdef MMIO_TIMEOUT_EN
                  err_timeout <= 1'b1;
`endif
                  if (!lat_write) begin
                     mmio_rd_data <= '1;
                  end
               end else begin
                  state <= WAIT;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/mmio_ctrl_gen.md
MMIO_CTRL_GEN -- requirements
Module: mmio_ctrl_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- SLOT_BITS, 6: slot-index bits; N_SLOT = 2^SLOT_BITS.
- REG_AW, 5: register-address bits per slot.
- SLOT_MASK, all ones (N_SLOT bits): bit i = 1 means slot i is populated.
- TIMEOUT, 255: wait-cycle limit, range 1..65535.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic on the rising edge.
- reset, in, 1: synchronous, active-high.
- mmio_cs, in, 1: bus request.
- mmio_wr, in, 1: write.
- mmio_rd, in, 1: read.
- mmio_addr, in, 21: word address; only the low SLOT_BITS+REG_AW bits are decoded.
- mmio_wr_data, in, 32: write data.
- mmio_rd_data, out, 32: read data.
- mmio_ready, out, 1: one-cycle completion pulse.
- slot_cs, out, N_SLOT: one-hot slot select.
- slot_rd, out, 1: read strobe.
- slot_wr, out, 1: write strobe.
- slot_reg_addr, out, REG_AW: register address, shared by all slots.
- slot_wr_data, out, 32: write data, shared by all slots.
- slot_rd_data, in, N_SLOT*32: flattened read data; slot i occupies bits [32i+31:32i].
- slot_ready, in, N_SLOT: per-slot access done.
- err_unmapped, out, 1: sticky flag.
- err_timeout, out, 1: sticky flag.
- err_clr, in, 1: clears both sticky flags.

Function
REQ-003 SHALL decode slot = mmio_addr[SLOT_BITS+REG_AW-1:REG_AW] and reg = mmio_addr[REG_AW-1:0].
REQ-004 SHALL implement FSM states IDLE, ACCESS, WAIT, DONE.
REQ-005 IDLE: when mmio_cs=1 and (mmio_rd or mmio_wr) = 1, SHALL latch slot, reg, wr_data and op.
- Populated slot: go to ACCESS.
- Unpopulated slot: go to DONE.
REQ-006 If mmio_rd and mmio_wr are both 1, SHALL treat the request as a write.
REQ-007 ACCESS SHALL last exactly one cycle and drive:
- slot_cs one-hot at the latched slot;
- slot_rd or slot_wr = 1;
- slot_reg_addr and slot_wr_data from the latched values.
REQ-008 slot_cs, slot_rd and slot_wr SHALL be 0 in every state except ACCESS.
REQ-009 slot_ready[latched slot] SHALL be sampled in ACCESS and WAIT.
- If 1: capture slot_rd_data of that slot (reads only) and go to DONE.
- Otherwise: go from ACCESS to WAIT, or stay in WAIT.
REQ-010 Minimum latency: request accepted at edge T, mmio_ready high in cycle T+2.
REQ-011 DONE SHALL drive mmio_ready=1 for exactly one cycle, then go to IDLE.
REQ-012 mmio_rd_data:
- SHALL update only in DONE of a read.
- SHALL hold its value otherwise.
- SHALL be 0xFFFFFFFF for an unmapped or timed-out read.
REQ-013 mmio_cs SHALL be ignored outside IDLE; no request queuing.
REQ-014 An unmapped access SHALL set err_unmapped in DONE and SHALL NOT assert any slot strobe.
REQ-015 Sticky flags:
- err_clr=1 SHALL clear both flags on the next edge.
- If a set and err_clr coincide, the set SHALL win.

Reset
REQ-016 While reset is high, the FSM SHALL go to IDLE and all outputs SHALL be 0, including mmio_rd_data, mmio_ready, slot_cs and both err flags.
REQ-017 Reset asserted mid-transaction SHALL abort it, with no mmio_ready pulse and no flag update.

Configuration
REQ-018 With macro MMIO_TIMEOUT_EN defined, a 16-bit counter SHALL count cycles spent in ACCESS and WAIT.
- If the count reaches TIMEOUT with slot_ready still low, the FSM SHALL go to DONE and set err_timeout.
- The counter SHALL clear on entry to ACCESS.
REQ-019 Without MMIO_TIMEOUT_EN:
- WAIT SHALL persist until slot_ready.
- err_timeout SHALL be tied to 0.
- No counter SHALL be synthesised.

Verification
REQ-020 Read slot 3, reg 5 (mmio_addr=0x065); slot_ready[3] tied 1; slot 3 data 0x12345678 -> one ACCESS cycle with slot_cs=0x8 and slot_reg_addr=5; mmio_ready at T+2; mmio_rd_data=0x12345678.
REQ-021 Write 0xA5A5A5A5 to slot 2 with slot_ready[2] delayed 4 cycles -> slot_wr high exactly one cycle; mmio_ready at T+6; mmio_rd_data unchanged.
REQ-022 SLOT_MASK bit 9 = 0; read slot 9 -> no slot strobes; mmio_rd_data=0xFFFFFFFF; err_unmapped=1 until err_clr.
REQ-023 MMIO_TIMEOUT_EN defined, TIMEOUT=8, slot_ready held 0 -> mmio_ready 9 cycles after acceptance; err_timeout=1; mmio_rd_data=0xFFFFFFFF.
REQ-024 Reset pulsed during WAIT -> no mmio_ready; all outputs 0; a new read afterwards completes normally.
REQ-025 mmio_rd=mmio_wr=1 together, and a second mmio_cs during WAIT -> request handled as a write; the second request is ignored.
